bus_mux_rr: RTL and testbench

//   Parametrised N-channel, WIDTH-bit bus multiplexer with a registered output stage
//   and valid/ready handshakes on every input and on the output.
//   Two selection modes: fixed select (external Sel) or round-robin arbitration.

---
 rtl/bus_mux_rr_if.sv | 28 ++
 rtl/bus_mux_rr.sv | 99 +++++++++
 tb/tb_bus_mux_rr.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bus_mux_rr_if.sv
// Handshake bundle between producers, the shared-bus mux and its consumer.
// The mux uses the slave modport; the driving environment uses master.
interface bus_mux_rr_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      Mode;
    logic [SEL_W-1:0]          Sel;
    logic [CHANNELS*WIDTH-1:0] In_Data;
    logic [CHANNELS-1:0]       In_Valid;
    logic [CHANNELS-1:0]       In_Ready;
    logic [WIDTH-1:0]          Out_Data;
    logic [SEL_W-1:0]          Out_Src;
    logic                      Out_Valid;
    logic                      Out_Ready;

    modport master (
        output Mode, Sel, In_Data, In_Valid, Out_Ready,
        input  In_Ready, Out_Data, Out_Src, Out_Valid
    );

    modport slave (
        input  Mode, Sel, In_Data, In_Valid, Out_Ready,
        output In_Ready, Out_Data, Out_Src, Out_Valid
    );
endinterface

// File: rtl/bus_mux_rr.sv
// N-channel registered bus mux: fixed-select or round-robin grant,
// valid/ready on every input and on the single output register.
module bus_mux_rr #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    bus_mux_rr_if.slave   bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    function automatic logic [SEL_W-1:0] wrap(input int v);
        return SEL_W'(v % CHANNELS);
    endfunction

    assign load_en = (state_q == EMPTY) || bus.Out_Ready;

    // Round-robin: scan from the far end so the nearest valid
    // channel after ptr is the last (winning) assignment.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (bus.Mode) begin
            for (int k = CHANNELS - 1; k >= 0; k--) begin
                if (bus.In_Valid[wrap(int'(ptr_q) + k)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = wrap(int'(ptr_q) + k);
                end
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.Sel == SEL_W'(i) && bus.In_Valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data     = '0;
        bus.In_Ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_idx == SEL_W'(i)) begin
                gnt_data = bus.In_Data[i*WIDTH +: WIDTH];
                bus.In_Ready[i] = Reset_n && load_en && gnt_vld;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            if (gnt_vld) begin
                state_d = FULL;
                data_d  = gnt_data;
                src_d   = gnt_idx;
                ptr_d   = (gnt_idx == SEL_W'(CHANNELS - 1))
                          ? '0 : gnt_idx + 1'b1;
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.Out_Valid = (state_q == FULL);
    assign bus.Out_Data  = data_q;
    assign bus.Out_Src   = src_q;
endmodule

// File: tb/tb_bus_mux_rr.sv
// Directed and randomized bench for bus_mux_rr against a
// transaction-level reference of the grant/handshake rules.
module tb_bus_mux_rr;
    localparam int W  = 16;
    localparam int C  = 4;
    localparam int C3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_mux_rr_if #(.WIDTH(W), .CHANNELS(C))  bus ();
    bus_mux_rr_if #(.WIDTH(W), .CHANNELS(C3)) bus3 ();

    bus_mux_rr #(.WIDTH(W), .CHANNELS(C)) dut (
        .Clk(clk), .Reset_n(rst_n), .bus(bus)
    );
    bus_mux_rr #(.WIDTH(W), .CHANNELS(C3)) dut3 (
        .Clk(clk), .Reset_n(rst_n), .bus(bus3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit             m_vld;
    logic [W-1:0]   m_data;
    int             m_src;
    int             m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_grant(input bit mode, input int sel,
                                     input logic [C-1:0] v, input int ptr);
        if (!mode)
            return (sel < C && v[sel] === 1'b1) ? sel : -1;
        for (int k = 0; k < C; k++)
            if (v[(ptr + k) % C] === 1'b1) return (ptr + k) % C;
        return -1;
    endfunction

    task automatic model_reset();
        m_vld = 0; m_data = '0; m_src = 0; m_ptr = 0;
    endtask

    task automatic set_ch(input int i, input logic [W-1:0] d);
        bus.In_Data[i*W +: W] = d;
    endtask

    // Inputs are already driven; check ready, clock once, check outputs.
    task automatic step(input string tag);
        int g;
        logic [C-1:0] exp_rdy;
        #1;
        g = ref_grant(bus.Mode, int'(bus.Sel), bus.In_Valid, m_ptr);
        exp_rdy = '0;
        if ((!m_vld || bus.Out_Ready) && g >= 0) exp_rdy[g] = 1'b1;
        chk({tag, ".rdy"}, 32'(bus.In_Ready), 32'(exp_rdy));
        @(posedge clk);
        if (!m_vld || bus.Out_Ready) begin
            if (g >= 0) begin
                m_vld  = 1;
                m_data = bus.In_Data[g*W +: W];
                m_src  = g;
                m_ptr  = (g + 1) % C;
            end else begin
                m_vld = 0;
            end
        end
        #1;
        chk({tag, ".vld"}, 32'(bus.Out_Valid), 32'(m_vld));
        chk({tag, ".data"}, 32'(bus.Out_Data), 32'(m_data));
        chk({tag, ".src"}, 32'(bus.Out_Src), 32'(m_src));
    endtask

    initial begin
        bus.Mode = 1'b1; bus.Sel = '0;
        bus.In_Data = '0; bus.In_Valid = '1; bus.Out_Ready = 1'b1;
        bus3.Mode = 1'b0; bus3.Sel = '0;
        bus3.In_Data = '0; bus3.In_Valid = '0; bus3.Out_Ready = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.vld", 32'(bus.Out_Valid), 32'd0);
        chk("rst.data", 32'(bus.Out_Data), 32'd0);
        chk("rst.src", 32'(bus.Out_Src), 32'd0);
        chk("rst.rdy", 32'(bus.In_Ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.In_Valid = '0;
        @(posedge clk);
        #1;

        // Fixed select
        bus.Mode = 1'b0; bus.Sel = 2'd2;
        set_ch(0, 16'h1111); set_ch(2, 16'hBEEF);
        bus.In_Valid = 4'b0101; bus.Out_Ready = 1'b1;
        #1;
        chk("fix.rdy", 32'(bus.In_Ready), 32'h4);
        step("fix");
        chk("fix.out", 32'(bus.Out_Data), 32'hBEEF);
        chk("fix.src2", 32'(bus.Out_Src), 32'd2);

        // Backpressure: hold BEEF, then drain and load together
        bus.Out_Ready = 1'b0;
        set_ch(2, 16'hCAFE);
        for (int i = 0; i < 3; i++) begin
            step("bp");
            chk("bp.hold", 32'(bus.Out_Data), 32'hBEEF);
        end
        bus.Out_Ready = 1'b1;
        step("bp.rel");
        chk("bp.next", 32'(bus.Out_Data), 32'hCAFE);
        chk("bp.nvld", 32'(bus.Out_Valid), 32'd1);

        // Transfer on ch3 brings the pointer back to 0
        bus.Sel = 2'd3; bus.In_Valid = 4'b1000;
        step("ptr0");

        // Round robin with every channel valid
        bus.Mode = 1'b1; bus.In_Valid = 4'b1111;
        for (int i = 0; i < C; i++) set_ch(i, 16'hA000 + 16'(i));
        for (int i = 0; i < 6; i++) begin
            step("rr");
            chk("rr.seq", 32'(bus.Out_Src), 32'(i % C));
            chk("rr.dat", 32'(bus.Out_Data), 32'hA000 + 32'(i % C));
            chk("rr.nobub", 32'(bus.Out_Valid), 32'd1);
        end

        // RR skip: set ptr to 1, only ch0 and ch3 valid
        bus.Mode = 1'b0; bus.Sel = 2'd0; bus.In_Valid = 4'b0001;
        step("ptr1");
        bus.Mode = 1'b1; bus.In_Valid = 4'b1001;
        step("skip.a");
        chk("skip.ch3", 32'(bus.Out_Src), 32'd3);
        step("skip.b");
        chk("skip.ch0", 32'(bus.Out_Src), 32'd0);

        // Selected channel not valid: drains to empty
        bus.Mode = 1'b0; bus.Sel = 2'd2; bus.In_Valid = 4'b1011;
        step("empty");
        chk("empty.vld", 32'(bus.Out_Valid), 32'd0);

        // Out-of-range select on the 3-channel instance
        bus3.Sel = 2'd3; bus3.In_Valid = 3'b111;
        bus3.In_Data = {16'h3333, 16'h2222, 16'h1111};
        #1;
        chk("c3.oor.rdy", 32'(bus3.In_Ready), 32'd0);
        @(posedge clk); #1;
        chk("c3.oor.vld", 32'(bus3.Out_Valid), 32'd0);
        bus3.Sel = 2'd2;
        #1;
        chk("c3.sel2.rdy", 32'(bus3.In_Ready), 32'h4);
        @(posedge clk); #1;
        chk("c3.sel2.dat", 32'(bus3.Out_Data), 32'h3333);
        chk("c3.sel2.src", 32'(bus3.Out_Src), 32'd2);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bus.Mode      = 1'($urandom);
            bus.Sel       = 2'($urandom);
            bus.In_Valid  = 4'($urandom);
            bus.In_Data   = {16'($urandom), 16'($urandom),
                             16'($urandom), 16'($urandom)};
            bus.Out_Ready = ($urandom_range(0, 3) != 0);
            step("rnd");
        end

        // Asynchronous reset while full
        bus.Mode = 1'b1; bus.In_Valid = 4'b1111; bus.Out_Ready = 1'b0;
        step("prerst");
        chk("prerst.full", 32'(bus.Out_Valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vld", 32'(bus.Out_Valid), 32'd0);
        chk("arst.data", 32'(bus.Out_Data), 32'd0);
        chk("arst.src", 32'(bus.Out_Src), 32'd0);
        chk("arst.rdy", 32'(bus.In_Ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.Out_Ready = 1'b1;
        step("postrst");
        chk("postrst.ptr", 32'(bus.Out_Src), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
